// File: rtl/hex_msg_pkg.sv
// Shared encodings for the hex message display controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hex_msg_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SCROLL = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_SHOW   = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  // Active-low g..a pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_msg_ctrl_seg.sv
// Hex nibble to active-low seven-segment pattern (bit order g..a).
// Latency: combinational.
// Backpressure: none.
module hex_seg_decode
  import hex_msg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Fixed lookup of the sixteen hex glyphs.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_msg_ctrl.sv
// Message buffer sequenced onto NUM_DIGITS seven-segment displays (static/scroll/blink).
// Latency: count updates at the accepting edge; hex_out follows one edge later.
// Backpressure: o_wr_ready drops while the buffer is full, during clear, and in reset.
module hex_msg_ctrl
  import hex_msg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int SCROLL_DIV = 12_500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_wr_valid,
  input  logic [3:0]              i_wr_data,
  output logic                    o_wr_ready,
  input  logic                    i_clear,
  input  logic [1:0]              i_mode,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  output logic [3:0]              o_count,
  output logic [7*NUM_DIGITS-1:0] o_hex_out
);

  localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4*MSG_LEN-1:0]    r_buf;
  logic [PW-1:0]           r_wr_ptr;
  logic [3:0]              r_count;
  logic [3:0]              r_start;
  logic [SW-1:0]           r_scroll_cnt;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_on;
  logic                    r_live;
  logic [1:0]              r_mode_q;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic                    w_wr_fire;
  logic                    w_mode_chg;
  logic                    w_scroll_tc;
  logic                    w_blink_tc;
  logic                    w_step;
  logic                    w_long_msg;
  logic [NUM_DIGITS-1:0]   w_vis;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [6:0]              w_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_hex_nxt;

  // r_live keeps the port closed on the reset edge itself.
  assign o_wr_ready  = r_live && (r_count < 4'(MSG_LEN)) && !i_clear;
  assign w_wr_fire   = i_wr_valid && o_wr_ready;
  assign w_mode_chg  = (i_mode != r_mode_q);
  assign w_long_msg  = (r_count > 4'(NUM_DIGITS));
  assign w_scroll_tc = (r_scroll_cnt == SW'(SCROLL_DIV - 1));
  assign w_blink_tc  = (r_blink_cnt == BW'(BLINK_DIV - 1));
  assign w_step      = (r_state == S_SCROLL) && w_scroll_tc && w_long_msg && !w_mode_chg;
  assign o_count     = r_count;
  assign o_hex_out   = r_hex;

  // Next display state: clear wins, otherwise follow the selected mode.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY:  if (w_wr_fire) w_state_nxt = (i_mode == MODE_SCROLL) ? S_SCROLL : S_SHOW;
        S_SHOW:   if (i_mode == MODE_SCROLL) w_state_nxt = S_SCROLL;
        S_SCROLL: if (i_mode != MODE_SCROLL) w_state_nxt = S_SHOW;
        default:  w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_EMPTY;
    else            r_state <= w_state_nxt;
  end

  // Message storage; contents beyond r_count are never shown, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) r_buf[4*int'(r_wr_ptr) +: 4] <= i_wr_data;
  end

  // Fill level, write pointer, scroll window and the two timebases.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_live       <= 1'b0;
      r_mode_q     <= MODE_STATIC;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_start      <= '0;
      r_scroll_cnt <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
    end else begin
      r_live   <= 1'b1;
      r_mode_q <= i_mode;

      if (i_clear) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
      end else if (w_wr_fire) begin
        r_count  <= r_count + 4'd1;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end

      // Window start wraps on the current fill level; a write this cycle widens it next cycle.
      if (i_clear || w_mode_chg) r_start <= '0;
      else if (w_step)           r_start <= (r_start + 4'd1 == r_count) ? 4'd0 : r_start + 4'd1;

      if (w_mode_chg)                r_scroll_cnt <= '0;
      else if (i_mode == MODE_SCROLL) r_scroll_cnt <= w_scroll_tc ? '0 : r_scroll_cnt + SW'(1);

      if (w_mode_chg) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (i_mode == MODE_BLINK) begin
        r_blink_cnt <= w_blink_tc ? '0 : r_blink_cnt + BW'(1);
        if (w_blink_tc) r_blink_on <= !r_blink_on;
      end
    end
  end

  // Pick the nibble for each display position k (k = 0 is the leftmost display).
  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_vis[k] = 1'b0;
      idx      = k;
      if (r_state == S_SCROLL && w_long_msg) begin
        idx = int'(r_start) + k;
        if (idx >= int'(r_count)) idx = idx - int'(r_count);
        w_vis[k] = 1'b1;
      end else if (r_state != S_EMPTY) begin
        w_vis[k] = (k < int'(r_count));
      end
      w_nib[k] = r_buf[4*idx +: 4];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decode u_dec (
      .i_nibble (w_nib[g]),
      .o_seg    (w_seg[g])
    );
  end

  // Blank muxing: hidden position, blink off phase or per-digit mask.
  always_comb begin
    w_hex_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_hex_nxt[7*i +: 7] = (w_vis[NUM_DIGITS-1-i] && r_blink_on && !i_blank_mask[i])
                            ? w_seg[NUM_DIGITS-1-i] : SEG_BLANK;
    end
  end

  // Segment output register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_hex <= '1;
    else            r_hex <= w_hex_nxt;
  end

endmodule

// File: tb/tb_hex_msg_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_hex_msg_ctrl;

  localparam int SD = 3;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [3:0]  wr_data;
  logic        wr_ready;
  logic        clear;
  logic [1:0]  mode;
  logic [3:0]  mask;
  logic [3:0]  count;
  logic [27:0] hex;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hex_msg_ctrl #(
    .NUM_DIGITS (4),
    .MSG_LEN    (8),
    .SCROLL_DIV (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .i_clear      (clear),
    .i_mode       (mode),
    .i_blank_mask (mask),
    .o_count      (count),
    .o_hex_out    (hex)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0]  msg [$];
  int          m_start, m_sc, m_bc;
  bit          m_on, m_live, m_scrolling, model_ok;
  logic [1:0]  m_mode_prev;
  logic [27:0] exp_hex;
  int          exp_count;

  function automatic logic [27:0] model_hex(input logic [3:0] msk);
    logic [27:0] h;
    int n, src;
    h = '1;
    n = msg.size();
    for (int k = 0; k < 4; k++) begin
      src = -1;
      if (n > 0) begin
        if (m_scrolling && n > 4) src = (m_start + k) % n;
        else if (k < n)           src = k;
      end
      if (src >= 0 && m_on && !msk[3-k]) h[7*(3-k) +: 7] = seg_tab[msg[src]][6:0];
    end
    return h;
  endfunction

  always @(posedge clk) begin : model_step
    logic [27:0] nxt;
    int  n0;
    bit  fire, chg, step;
    nxt = model_hex(mask);
    if (!rst_n) begin
      msg.delete();
      m_start = 0; m_sc = 0; m_bc = 0; m_on = 1'b1;
      m_live = 1'b0; m_scrolling = 1'b0; m_mode_prev = 2'd0;
      exp_hex = '1;
    end else begin
      n0   = msg.size();
      fire = wr_valid && m_live && n0 < 8 && !clear;
      chg  = (mode != m_mode_prev);
      step = m_scrolling && m_sc == SD - 1 && n0 > 4 && !chg;
      if (clear)     msg.delete();
      else if (fire) msg.push_back(wr_data);
      if (clear || chg) m_start = 0;
      else if (step)    m_start = (m_start + 1) % n0;
      if (chg)              m_sc = 0;
      else if (mode == 2'd1) m_sc = (m_sc + 1) % SD;
      if (chg) begin
        m_bc = 0; m_on = 1'b1;
      end else if (mode == 2'd2) begin
        if (m_bc == BD - 1) begin m_bc = 0; m_on = !m_on; end
        else m_bc = m_bc + 1;
      end
      m_scrolling = !clear && msg.size() > 0 && mode == 2'd1;
      m_mode_prev = mode;
      m_live      = 1'b1;
      exp_hex     = nxt;
    end
    exp_count = msg.size();
    model_ok  = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("hex_vs_model",   32'(hex),   32'(exp_hex));
      chk("count_vs_model", 32'(count), 32'(exp_count));
      chk("ready_vs_model", 32'(wr_ready),
          32'(m_live && msg.size() < 8 && !clear));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] d);
    wr_valid = 1'b1; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  localparam logic [6:0] B7 = 7'h7F;

  initial begin
    model_ok = 1'b0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 4'h0; clear = 1'b0; mode = 2'd0; mask = 4'h0;

    // Reset and idle.
    tick(3);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_hex",   32'(hex), 32'h0FFFFFFF);
    rst_n = 1'b1;
    tick(5);
    chk("idle_hex",   32'(hex), 32'h0FFFFFFF);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_ready", 32'(wr_ready), 32'd1);

    // Static: 1, 2 left-aligned.
    wr(4'h1); wr(4'h2);
    chk("static_count", 32'(count), 32'd2);
    tick();
    chk("static_hex", 32'(hex), 32'({7'h79, 7'h24, B7, B7}));
    chk("model_static_hex", 32'(exp_hex), 32'({7'h79, 7'h24, B7, B7}));

    // Fill 0..7, then a refused ninth write.
    do_clear();
    for (int i = 0; i < 8; i++) wr(4'(i));
    wr_valid = 1'b1; wr_data = 4'h5;
    chk("full_ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    chk("full_count", 32'(count), 32'd8);
    tick();
    chk("full_hex", 32'(hex), 32'({7'h40, 7'h79, 7'h24, 7'h30}));

    // Scroll every SD cycles, wrapping after 8 steps.
    mode = 2'd1;
    tick(5);
    chk("scroll_1234", 32'(hex), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    tick(3);
    chk("scroll_2345", 32'(hex), 32'({7'h24, 7'h30, 7'h19, 7'h12}));
    tick(18);
    chk("scroll_wrap", 32'(hex), 32'({7'h40, 7'h79, 7'h24, 7'h30}));
    chk("model_scroll_wrap", 32'(exp_hex), 32'({7'h40, 7'h79, 7'h24, 7'h30}));

    // Blink with A,B,C,D.
    mode = 2'd0;
    do_clear();
    wr(4'hA); wr(4'hB); wr(4'hC); wr(4'hD);
    mode = 2'd2;
    tick(2);
    chk("blink_on",  32'(hex), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
    tick(4);
    chk("blink_off", 32'(hex), 32'h0FFFFFFF);
    tick(4);
    chk("blink_on2", 32'(hex), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
    mask = 4'b0001;
    tick();
    chk("blink_mask_on",  32'(hex), 32'({7'h08, 7'h03, 7'h46, B7}));
    tick(4);
    chk("blink_mask_off", 32'(hex), 32'h0FFFFFFF);

    // clear beats a simultaneous write.
    mode = 2'd0; mask = 4'h0;
    tick();
    clear = 1'b1; wr_valid = 1'b1; wr_data = 4'h9;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
    tick();
    chk("clear_hex", 32'(hex), 32'h0FFFFFFF);
    wr(4'h9);
    tick();
    chk("after_clear_hex", 32'(hex), 32'({7'h10, B7, B7, B7}));

    // Reset in the middle of scrolling six entries.
    do_clear();
    mode = 2'd1;
    for (int i = 1; i <= 6; i++) wr(4'(i));
    tick(7);
    rst_n = 1'b0;
    tick();
    chk("midrst_hex",   32'(hex), 32'h0FFFFFFF);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      wr_valid = ($urandom_range(0, 9) < 4);
      wr_data  = 4'($urandom_range(0, 15));
      clear    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) mask = 4'($urandom_range(0, 15));
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; wr_valid = 1'b0; clear = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
